receiver: RTL and testbench

Serial-to-parallel UART receive engine, the receive-side counterpart of the design's UART transmitter. It samples the asynchronous `rxd` line in the `clk` domain and recovers 8N1-style frames: one start bit (0), `WORD_WIDTH` data bits LSB first, and one stop bit (1). Each good word is pushed into a downstream FIFO through a single-cycle write strobe. Framing errors and FIFO overruns are reported as one-cycle pulses.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/bit_synchronizer.sv | 30 +++
 rtl/receiver.sv | 188 ++++++++++++++++++
 tb/tb_receiver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_t          receiver FSM state encoding (3 bits)
//   clocks_per_bit() clk cycles per serial bit (integer division)
//   majority3()      2-of-3 vote used when RECEIVER_MAJORITY_VOTE_EN is defined
package uart_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_START,
        STATE_DATA,
        STATE_STOP,
        STATE_WRITE,
        STATE_BREAK
    } state_t;

    function automatic int unsigned clocks_per_bit(input int unsigned freq,
                                                   input int unsigned baud);
        return freq / baud;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk      destination clock
//   rst_n    asynchronous active-low reset; both flops load ResetValue
//   d_i      asynchronous input
//   q_o      synchronized output (two clk edges of latency)
module bit_synchronizer #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receive engine: recovers start/WORD_WIDTH data (LSB first)/stop frames
// from rxd and pushes each good word to a FIFO with a one-cycle write strobe.
//   clk, rst_n     clock and asynchronous active-low reset
//   rxd            asynchronous serial line, idles high
//   full           downstream FIFO full, looked at only at the stop-bit decision
//   dout           received word, valid while we=1, held between strobes
//   we             one-cycle FIFO write strobe
//   busy           high whenever the FSM is not idle
//   framing_error  one-cycle pulse when the stop bit reads 0
//   overrun        one-cycle pulse when a good word is dropped because full=1
// Build option RECEIVER_MAJORITY_VOTE_EN: each bit decision is a 2-of-3 vote
// over target-1/target/target+1, decided one cycle later.
module receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd230400,
    parameter int unsigned WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  we,
    output logic                  busy,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int unsigned BitCntW        = $clog2(WORD_WIDTH + 1);

    localparam logic [31:0]        HalfTarget = 32'(HALF_BIT);
    localparam logic [31:0]        BitTarget  = 32'(CLOCKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit    = BitCntW'(WORD_WIDTH - 1);

`ifdef RECEIVER_MAJORITY_VOTE_EN
    // Decide one cycle late and reload to 1 so the bit period stays CLOCKS_PER_BIT.
    localparam logic [31:0] DecOffset = 32'd1;
    localparam logic [31:0] CntReload = 32'd1;
`else
    localparam logic [31:0] DecOffset = 32'd0;
    localparam logic [31:0] CntReload = 32'd0;
`endif

    logic rx_s;

    bit_synchronizer #(
        .ResetValue (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rxd),
        .q_o   (rx_s)
    );

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [WORD_WIDTH-1:0]  dout_q, dout_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                   fe_q, fe_d;
    logic                   ov_q, ov_d;

    logic [31:0] target;
    logic        decide;
    logic        sample_bit;

    assign target = (state_q == STATE_START) ? HalfTarget : BitTarget;
    assign decide = (cnt_q == target + DecOffset);

`ifdef RECEIVER_MAJORITY_VOTE_EN
    // vote_q[1] holds the target-1 sample, vote_q[0] the target sample.
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 2'b11;
        end else begin
            if (cnt_q == target - 32'd1) vote_q[1] <= rx_s;
            if (cnt_q == target)         vote_q[0] <= rx_s;
        end
    end

    assign sample_bit = majority3(vote_q[1], vote_q[0], rx_s);
`else
    assign sample_bit = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        shift_d   = shift_q;
        dout_d    = dout_q;
        bit_cnt_d = bit_cnt_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;

        unique case (state_q)
            STATE_IDLE: begin
                cnt_d = 32'd0;
                if (!rx_s) state_d = STATE_START;
            end
            STATE_START: begin
                if (decide) begin
                    cnt_d = CntReload;
                    if (!sample_bit) begin
                        state_d   = STATE_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        // False start: drop back silently.
                        state_d = STATE_IDLE;
                        cnt_d   = 32'd0;
                    end
                end
            end
            STATE_DATA: begin
                if (decide) begin
                    cnt_d   = CntReload;
                    shift_d = {sample_bit, shift_q[WORD_WIDTH-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        state_d = STATE_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STATE_STOP: begin
                if (decide) begin
                    cnt_d = 32'd0;
                    if (!sample_bit) begin
                        fe_d    = 1'b1;
                        state_d = STATE_BREAK;
                    end else if (full) begin
                        ov_d    = 1'b1;
                        state_d = STATE_IDLE;
                    end else begin
                        dout_d  = shift_q;
                        state_d = STATE_WRITE;
                    end
                end
            end
            STATE_WRITE: begin
                cnt_d   = 32'd0;
                state_d = STATE_IDLE;
            end
            STATE_BREAK: begin
                // Hold here until the line is released so a stuck-low line
                // cannot be read as an endless stream of frames.
                cnt_d = 32'd0;
                if (rx_s) state_d = STATE_IDLE;
            end
            default: begin
                cnt_d   = 32'd0;
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            cnt_q     <= 32'd0;
            shift_q   <= '0;
            dout_q    <= '0;
            bit_cnt_q <= '0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            bit_cnt_q <= bit_cnt_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign dout          = dout_q;
    assign we            = (state_q == STATE_WRITE);
    assign busy          = (state_q != STATE_IDLE);
    assign framing_error = fe_q;
    assign overrun       = ov_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver at CLOCKS_PER_BIT = 10, WORD_WIDTH = 8.
// Each sent good word is pushed to exp_q; the negedge monitor pops and
// compares on every we strobe.
module tb_receiver;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       full;
    logic [7:0] dout;
    logic       we;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fall = 0;
    int last_lat  = -1;
    int we_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    receiver #(
        .CLOCK_FREQUENCY (32'd1_000_000),
        .BAUD_RATE       (32'd100_000),
        .WORD_WIDTH      (32'd8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .full          (full),
        .dout          (dout),
        .we            (we),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (we) begin
            we_cnt   = we_cnt + 1;
            last_lat = cyc - last_fall;
            checks   = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_we: got dout=%h, expected no write", dout);
            end else begin
                exp_b = exp_q.pop_front();
                if (dout !== exp_b) begin
                    errors = errors + 1;
                    $display("FAIL word: got dout=%h, expected %h", dout, exp_b);
                end
            end
        end
        if (framing_error === 1'b1) fe_cnt = fe_cnt + 1;
        if (overrun === 1'b1)       ov_cnt = ov_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
        if (push) exp_q.push_back(b);
        rxd       = 1'b0;
        last_fall = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
`ifdef RECEIVER_MAJORITY_VOTE_EN
            // One-cycle inverted glitch at the bit centre; the vote must reject it.
            rxd = b[i];
            tick(6);
            rxd = ~b[i];
            tick(1);
            rxd = b[i];
            tick(3);
`else
            rxd = b[i];
            tick(CPB);
`endif
        end
        rxd = stop_bit;
        tick(CPB);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        full  = 1'b0;
        tick(3);
        checks++;
        if ({dout, we, busy, framing_error, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got dout=%h we=%b busy=%b fe=%b ov=%b, expected all 0",
                     dout, we, busy, framing_error, overrun);
        end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single;
        int w0, f0, o0;
        int lo, hi;
        w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(5);
        checks++;
        if (we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL single_we_count: got %0d, expected 1", we_cnt - w0);
        end
        // Nominal 98 cycles; the IDLE->START registration may add one, the vote one more.
`ifdef RECEIVER_MAJORITY_VOTE_EN
        lo = 99; hi = 100;
`else
        lo = 98; hi = 99;
`endif
        checks++;
        if (last_lat < lo || last_lat > hi) begin
            errors++;
            $display("FAIL single_latency: got %0d, expected %0d..%0d", last_lat, lo, hi);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++;
            $display("FAIL single_errors: got fe=%0d ov=%0d, expected 0 0",
                     fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = we_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(5);
        checks++;
        if (we_cnt - w0 != 3) begin
            errors++;
            $display("FAIL b2b_we_count: got %0d, expected 3", we_cnt - w0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d words left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_glitch;
        int w0, f0;
        w0 = we_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b, expected 1", busy);
        end
        @(posedge clk);
        #1;
        tick(7);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_low: got %b, expected 0", busy);
        end
        @(posedge clk);
        #1;
        tick(10);
        checks++;
        if (we_cnt != w0 || fe_cnt != f0) begin
            errors++;
            $display("FAIL glitch_pulses: got we=%0d fe=%0d, expected 0 0",
                     we_cnt - w0, fe_cnt - f0);
        end
    endtask

    task automatic test_framing;
        int w0, f0;
        w0 = we_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        tick(40);
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++;
            $display("FAIL framing_count: got %0d, expected 1", fe_cnt - f0);
        end
        checks++;
        if (we_cnt != w0) begin
            errors++;
            $display("FAIL framing_we: got %0d, expected 0", we_cnt - w0);
        end
        rxd = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_exit: got busy=%b, expected 0", busy);
        end
        send_frame(8'h12, 1'b1, 1'b1);
        tick(5);
        checks++;
        if (we_cnt - w0 != 1 || fe_cnt - f0 != 1) begin
            errors++;
            $display("FAIL framing_recover: got we=%0d fe=%0d, expected 1 1",
                     we_cnt - w0, fe_cnt - f0);
        end
    endtask

    task automatic test_overrun;
        int w0, o0;
        w0 = we_cnt; o0 = ov_cnt;
        full = 1'b1;
        send_frame(8'h77, 1'b1, 1'b0);
        full = 1'b0;
        tick(3);
        checks++;
        if (ov_cnt - o0 != 1 || we_cnt != w0) begin
            errors++;
            $display("FAIL overrun: got ov=%0d we=%0d, expected 1 0", ov_cnt - o0, we_cnt - w0);
        end
        send_frame(8'h88, 1'b1, 1'b1);
        tick(5);
        checks++;
        if (we_cnt - w0 != 1 || dout !== 8'h88) begin
            errors++;
            $display("FAIL overrun_recover: got we=%0d dout=%h, expected 1 88",
                     we_cnt - w0, dout);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        int w0, f0, o0;
        b = 8'h99;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, we, busy, framing_error, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset: got dout=%h we=%b busy=%b fe=%b ov=%b, expected all 0",
                     dout, we, busy, framing_error, overrun);
        end
        w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
        tick(5);
        rxd = 1'b1;
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (we_cnt != w0 || fe_cnt != f0 || ov_cnt != o0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: got we=%0d fe=%0d ov=%0d busy=%b, expected 0 0 0 0",
                     we_cnt - w0, fe_cnt - f0, ov_cnt - o0, busy);
        end
        send_frame(8'h42, 1'b1, 1'b1);
        tick(20);
        checks++;
        if (dout !== 8'h42 || we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL post_reset_frame: got dout=%h we=%0d, expected 42 1",
                     dout, we_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
